// File: rtl/ysyx_22040750_ifu_axi_pkg.sv
// Shared definitions for the instruction-fetch AXI4-Lite bridge:
// FSM state encoding, AXI constants and small address helpers.
package ysyx_22040750_pkg;

   // FSM state type and encoding (legacy-compatible plain constants)
   typedef logic [1:0] ifu_state_t;

   localparam ifu_state_t ST_IDLE = 2'd0;
   localparam ifu_state_t ST_AR   = 2'd1;
   localparam ifu_state_t ST_R    = 2'd2;

   // AXI encodings used by the bridge
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [2:0] AXI_SIZE_4B   = 3'b010;

   // A fetch address is misaligned when either of its two low bits is set
   function automatic logic req_misaligned(input logic [1:0] addr_lo);
      return (addr_lo != 2'b00);
   endfunction

   // Error class of an AXI response: SLVERR/DECERR both set bit 1
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/ysyx_22040750_ifu_axi_if.sv
// Bundle of the IF-stage request/response signals and the AXI4-Lite read
// channels of the fetch bridge. "master" is the bridge side, "slave" is the
// environment (IF stage plus AXI slave). O_inst_err exists only when
// IFU_ERR_EN is defined.
interface ysyx_22040750_ifu_axi_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   // IF-stage side
   logic              I_req_valid;
   logic [ADDR_W-1:0] I_req_addr;
   logic              O_req_ready;
   logic              O_inst_valid;
   logic [31:0]       O_inst;
   logic              I_flush;
`ifdef IFU_ERR_EN
   logic              O_inst_err;
`endif

   // AXI read address / read data channels
   logic [ADDR_W-1:0] O_araddr;
   logic              O_arvalid;
   logic [2:0]        O_arsize;
   logic              I_arready;
   logic              I_rvalid;
   logic [DATA_W-1:0] I_rdata;
   logic [1:0]        I_rresp;
   logic              O_rready;

   modport master (
`ifdef IFU_ERR_EN
      output O_inst_err,
`endif
      input  I_req_valid, I_req_addr, I_flush,
      output O_req_ready, O_inst_valid, O_inst,
      output O_araddr, O_arvalid, O_arsize, O_rready,
      input  I_arready, I_rvalid, I_rdata, I_rresp
   );

   modport slave (
`ifdef IFU_ERR_EN
      input  O_inst_err,
`endif
      output I_req_valid, I_req_addr, I_flush,
      input  O_req_ready, O_inst_valid, O_inst,
      input  O_araddr, O_arvalid, O_arsize, O_rready,
      output I_arready, I_rvalid, I_rdata, I_rresp
   );

endinterface

// File: rtl/ysyx_22040750_ifu_axi.sv
// Instruction-fetch bus bridge: turns one IF-stage fetch request into one
// AXI4-Lite read and returns the selected 32-bit instruction as a one-cycle
// pulse. A flush while the read is outstanding drops the response.
// Optional feature macro: IFU_ERR_EN (misalignment check, rresp error and
// the O_inst_err output).
module ysyx_22040750_ifu_axi
   import ysyx_22040750_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32
) (
   input logic                      I_sys_clk,
   input logic                      I_rst,
   ysyx_22040750_ifu_axi_if.master  bus
);

   ifu_state_t        state_r;
   logic              discard_r;
   logic              addr_b2_r;
   logic [ADDR_W-1:0] araddr_r;
   logic              arvalid_r;
   logic              rready_r;
   logic              inst_valid_r;
   logic [31:0]       inst_r;
`ifdef IFU_ERR_EN
   logic              inst_err_r;
`endif

   logic              req_fire_s;
   logic              r_fire_s;
   logic              misaligned_s;
   logic              resp_err_s;
   logic [31:0]       rdata_word_s;
   logic              unused_s;

   assign req_fire_s = bus.I_req_valid && (state_r == ST_IDLE);
   assign r_fire_s   = bus.I_rvalid && rready_r;

`ifdef IFU_ERR_EN
   assign misaligned_s = req_misaligned(bus.I_req_addr[1:0]);
   assign resp_err_s   = resp_is_err(bus.I_rresp);
`else
   // Low address bits are simply masked and the response code is ignored
   assign misaligned_s = 1'b0;
   assign resp_err_s   = 1'b0;
`endif

   // Bits that only matter in some configurations
   assign unused_s = ^{bus.I_rresp, bus.I_req_addr[1:0], addr_b2_r, resp_err_s};

   // Pick the 32-bit word addressed by the latched address bit 2
   generate
      if (DATA_W == 64) begin : g_dw64
         // Upper half of the beat holds the word at addr[2]==1
         always_comb begin
            if (addr_b2_r) begin
               rdata_word_s = bus.I_rdata[63:32];
            end else begin
               rdata_word_s = bus.I_rdata[31:0];
            end
         end
      end else begin : g_dw32
         // A 32-bit bus returns the requested word directly
         always_comb begin
            rdata_word_s = bus.I_rdata[31:0];
         end
      end
   endgenerate

   // Fetch FSM, discard tracking and registered outputs
   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         state_r      <= ST_IDLE;
         discard_r    <= 1'b0;
         addr_b2_r    <= 1'b0;
         araddr_r     <= {ADDR_W{1'b0}};
         arvalid_r    <= 1'b0;
         rready_r     <= 1'b0;
         inst_valid_r <= 1'b0;
         inst_r       <= 32'd0;
`ifdef IFU_ERR_EN
         inst_err_r   <= 1'b0;
`endif
      end else begin
         // The instruction strobe is a single-cycle pulse
         inst_valid_r <= 1'b0;
`ifdef IFU_ERR_EN
         inst_err_r   <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
               // Flush in IDLE is ignored: a same-cycle request is the redirect target
               if (req_fire_s && misaligned_s) begin
                  inst_valid_r <= 1'b1;
                  inst_r       <= 32'd0;
`ifdef IFU_ERR_EN
                  inst_err_r   <= 1'b1;
`endif
               end else if (req_fire_s) begin
                  araddr_r  <= {bus.I_req_addr[ADDR_W-1:2], 2'b00};
                  addr_b2_r <= bus.I_req_addr[2];
                  arvalid_r <= 1'b1;
                  state_r   <= ST_AR;
               end
            end
            ST_AR: begin
               // AR is never withdrawn once raised; a flush only marks the reply
               if (bus.I_flush) begin
                  discard_r <= 1'b1;
               end
               if (bus.I_arready) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  state_r   <= ST_R;
               end
            end
            ST_R: begin
               if (r_fire_s) begin
                  rready_r  <= 1'b0;
                  discard_r <= 1'b0;
                  state_r   <= ST_IDLE;
                  if (!discard_r && !bus.I_flush) begin
                     inst_valid_r <= 1'b1;
                     inst_r       <= rdata_word_s;
`ifdef IFU_ERR_EN
                     inst_err_r   <= resp_err_s;
`endif
                  end
               end else if (bus.I_flush) begin
                  discard_r <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               discard_r <= 1'b0;
               arvalid_r <= 1'b0;
               rready_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.O_req_ready  = (state_r == ST_IDLE);
   assign bus.O_inst_valid = inst_valid_r;
   assign bus.O_inst       = inst_r;
   assign bus.O_araddr     = araddr_r;
   assign bus.O_arvalid    = arvalid_r;
   assign bus.O_arsize     = AXI_SIZE_4B;
   assign bus.O_rready     = rready_r;
`ifdef IFU_ERR_EN
   assign bus.O_inst_err   = inst_err_r;
`endif

endmodule

// File: tb/tb_ysyx_22040750_ifu_axi.sv
// Self-checking bench for the instruction-fetch AXI bridge: directed
// scenarios followed by randomized fetches against a simple memory model.
module tb_ysyx_22040750_ifu_axi;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 32;

   logic   I_sys_clk = 1'b0;
   logic   I_rst     = 1'b1;
   int     n_assert  = 0;
   int     n_fail    = 0;
   longint cyc       = 0;
   longint last_valid_cyc = 0;

   ysyx_22040750_ifu_axi_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ysyx_22040750_ifu_axi #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .I_sys_clk (I_sys_clk),
      .I_rst     (I_rst),
      .bus       (bus)
   );

   always #5 I_sys_clk = ~I_sys_clk;

   always @(posedge I_sys_clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory contents: every aligned word has a distinct pseudo-random value
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hffff_fffc;
      return (w * 32'h9e37_79b1) ^ 32'h0bad_f00d;
   endfunction

   // 64-bit beat covering the 8-byte line that holds address a
   function automatic logic [63:0] mem_line(input logic [31:0] a);
      logic [31:0] base;
      base = a & 32'hffff_fff8;
      return {mem_word(base + 32'd4), mem_word(base)};
   endfunction

   task automatic idle_inputs();
      bus.I_req_valid = 1'b0;
      bus.I_req_addr  = 32'd0;
      bus.I_flush     = 1'b0;
      bus.I_arready   = 1'b0;
      bus.I_rvalid    = 1'b0;
      bus.I_rdata     = 64'd0;
      bus.I_rresp     = 2'b00;
   endtask

   // One fetch; cycle 0 = request cycle, hs = R handshake cycle.
   // flush_c < 0 means no flush. Called and returning at a negedge.
   task automatic fetch(input logic [31:0] addr, input logic [63:0] rdata,
                        input logic [1:0] rresp, input int ar_dly, input int r_dly,
                        input int flush_c, input logic [31:0] exp_inst,
                        input logic exp_drop);
      int hs;
      longint start;
      logic [31:0] al;
      hs    = ar_dly + r_dly + 2;
      al    = addr & 32'hffff_fffc;
      start = cyc;
      for (int c = 0; c <= hs; c++) begin
         if (c == 0) check("req_ready_idle", bus.O_req_ready, 1);
         if (c == 1) check("inst_valid_pulse", bus.O_inst_valid, 0);
         if (c >= 1 && c <= ar_dly + 1) begin
            check("arvalid_hold", bus.O_arvalid, 1);
            check("araddr_hold", bus.O_araddr, al);
            check("arsize", bus.O_arsize, 3'b010);
            check("req_ready_busy", bus.O_req_ready, 0);
         end
         if (c > ar_dly + 1) begin
            check("rready_in_r", bus.O_rready, 1);
            check("arvalid_low_in_r", bus.O_arvalid, 0);
         end
         bus.I_req_valid = (c == 0);
         bus.I_req_addr  = addr;
         bus.I_arready   = (c == ar_dly + 1);
         bus.I_rvalid    = (c == hs);
         bus.I_rdata     = (c == hs) ? rdata : {$urandom, $urandom};
         bus.I_rresp     = rresp;
         bus.I_flush     = (c == flush_c);
         @(posedge I_sys_clk);
         @(negedge I_sys_clk);
      end
      idle_inputs();
      check("inst_valid", bus.O_inst_valid, !exp_drop);
      if (!exp_drop) begin
         check("inst_data", bus.O_inst, exp_inst);
         last_valid_cyc = cyc;
         if (ar_dly == 0 && r_dly == 0) check("latency", cyc - start, 3);
      end
`ifdef IFU_ERR_EN
      check("inst_err", bus.O_inst_err, rresp[1] && !exp_drop);
`endif
      check("req_ready_after", bus.O_req_ready, 1);
      check("rready_after", bus.O_rready, 0);
   endtask

   initial begin
      longint v1;
      logic [31:0] a;
      int ad, rd, hs, fc;
      logic [1:0] rr;

      idle_inputs();
      I_rst = 1'b1;
      repeat (2) @(posedge I_sys_clk);
      @(negedge I_sys_clk);
      check("rst_req_ready", bus.O_req_ready, 1);
      check("rst_arvalid", bus.O_arvalid, 0);
      check("rst_rready", bus.O_rready, 0);
      check("rst_inst_valid", bus.O_inst_valid, 0);
      check("rst_inst", bus.O_inst, 0);
      check("rst_araddr", bus.O_araddr, 0);
`ifdef IFU_ERR_EN
      check("rst_inst_err", bus.O_inst_err, 0);
`endif
      I_rst = 1'b0;
      @(negedge I_sys_clk);

      // Zero-wait fetch of the upper word
      fetch(32'h8000_0004, 64'h0010_0093_0000_0413, 2'b00, 0, 0, -1, 32'h0010_0093, 1'b0);

      // Slow AR with flush in cycle 2: response dropped
      fetch(32'h8000_0008, mem_line(32'h8000_0008), 2'b00, 3, 0, 2, 32'd0, 1'b1);

      // Flush on the R handshake, then a clean fetch
      fetch(32'h8000_0010, mem_line(32'h8000_0010), 2'b00, 0, 0, 2, 32'd0, 1'b1);
      fetch(32'h8000_0100, mem_line(32'h8000_0100), 2'b00, 0, 0, -1,
            mem_word(32'h8000_0100), 1'b0);

      // Back-to-back lower/upper halves, three cycles apart
      fetch(32'h8000_0000, mem_line(32'h8000_0000), 2'b00, 0, 0, -1,
            mem_word(32'h8000_0000), 1'b0);
      v1 = last_valid_cyc;
      fetch(32'h8000_0004, mem_line(32'h8000_0004), 2'b00, 0, 0, -1,
            mem_word(32'h8000_0004), 1'b0);
      check("b2b_spacing", last_valid_cyc - v1, 3);

      // Reset while waiting in R
      bus.I_req_valid = 1'b1;
      bus.I_req_addr  = 32'h8000_0020;
      @(posedge I_sys_clk);
      @(negedge I_sys_clk);
      bus.I_req_valid = 1'b0;
      bus.I_arready   = 1'b1;
      @(posedge I_sys_clk);
      @(negedge I_sys_clk);
      bus.I_arready   = 1'b0;
      check("pre_rst_rready", bus.O_rready, 1);
      I_rst           = 1'b1;
      bus.I_rvalid    = 1'b1;
      bus.I_rdata     = mem_line(32'h8000_0020);
      @(posedge I_sys_clk);
      @(negedge I_sys_clk);
      I_rst = 1'b0;
      idle_inputs();
      check("midrst_req_ready", bus.O_req_ready, 1);
      check("midrst_rready", bus.O_rready, 0);
      check("midrst_inst_valid", bus.O_inst_valid, 0);
      check("midrst_arvalid", bus.O_arvalid, 0);
      fetch(32'h8000_0024, mem_line(32'h8000_0024), 2'b00, 1, 2, -1,
            mem_word(32'h8000_0024), 1'b0);

`ifdef IFU_ERR_EN
      // Misaligned request: immediate error, no AR
      bus.I_req_valid = 1'b1;
      bus.I_req_addr  = 32'h8000_0002;
      @(posedge I_sys_clk);
      @(negedge I_sys_clk);
      idle_inputs();
      check("mis_arvalid", bus.O_arvalid, 0);
      check("mis_inst_valid", bus.O_inst_valid, 1);
      check("mis_inst_err", bus.O_inst_err, 1);
      check("mis_inst", bus.O_inst, 0);
      check("mis_req_ready", bus.O_req_ready, 1);
      @(negedge I_sys_clk);
      check("mis_pulse_end", bus.O_inst_valid, 0);
      // Slave error response on an aligned fetch
      fetch(32'h8000_0040, mem_line(32'h8000_0040), 2'b10, 0, 1, -1,
            mem_word(32'h8000_0040), 1'b0);
`endif

      // Randomized fetches: the IF stage must get the word at the request
      // address unless a flush arrived after the request cycle
      for (int i = 0; i < 40; i++) begin
         a = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
`ifndef IFU_ERR_EN
         a = a | 32'($urandom_range(0, 3));
`endif
         ad = $urandom_range(0, 3);
         rd = $urandom_range(0, 3);
         hs = ad + rd + 2;
         fc = ($urandom_range(0, 2) == 0) ? $urandom_range(0, hs) : -1;
         rr = 2'($urandom_range(0, 3));
         fetch(a, mem_line(a), rr, ad, rd, fc, mem_word(a), fc >= 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
